// File: rtl/alu_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// alu_scheduler_pkg
//   Shared types for the ALU issue scheduler: machine word, ALU opcode and
//   control bundle, op latency classes, scheduler FSM states, default
//   latencies and the opcode -> latency-class decoder.
//   No ports (package).
// ---------------------------------------------------------------------------
package alu_scheduler_pkg;

   localparam int XLEN = 64;

   typedef logic [XLEN-1:0] memory_word_t;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE,
      ALU_MUL, ALU_MULH, ALU_MULHU, ALU_MULHSU, ALU_MULW,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
      ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW
   } aluop_e;

   // usign selects the unsigned flavour of compares (e.g. BLT -> BLTU).
   typedef struct packed {
      aluop_e aluop;
      logic   usign;
   } control_bits_t;

   typedef enum logic [1:0] {
      OPC_SINGLE,
      OPC_MUL,
      OPC_DIV
   } op_class_e;

   typedef enum logic {
      S_IDLE,
      S_EXEC
   } alu_sched_state_e;

   localparam int DEFAULT_MUL_LATENCY = 3;
   localparam int DEFAULT_DIV_LATENCY = 8;

   function automatic op_class_e op_class(input aluop_e aluop);
      case (aluop)
         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
         ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW: op_class = OPC_DIV;
         ALU_MUL, ALU_MULH, ALU_MULHU, ALU_MULHSU,
         ALU_MULW:                                 op_class = OPC_MUL;
         default:                                  op_class = OPC_SINGLE;
      endcase
   endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// ---------------------------------------------------------------------------
// alu_scheduler_if
//   Bundles every non-clock/reset signal of the scheduler.
//   modport master : the scheduler itself
//   modport slave  : the surroundings (requesters, ALU, result consumer)
//   Signals: flush; req_valid/req_ctrl/req_src_a/req_src_b/req_tag and the
//   one-hot grant; alu_ctrl/alu_src_a/alu_src_b toward the ALU and
//   alu_result/alu_take_branch back; res_valid/res_ready with
//   res_tag/res_value/res_take_branch.
//
//   Handshakes: a request transfers in the cycle grant[i] is high (grant is
//   only ever raised for a requester whose req_valid is high, and the
//   requester keeps req_* stable until then). A result transfers in the
//   cycle res_valid && res_ready; while res_valid is high and res_ready is
//   low the res_* payload holds still.
// ---------------------------------------------------------------------------
interface alu_scheduler_if
   import alu_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 4
);

   logic                                flush;
   logic          [NUM_REQ-1:0]         req_valid;
   control_bits_t [NUM_REQ-1:0]         req_ctrl;
   memory_word_t  [NUM_REQ-1:0]         req_src_a;
   memory_word_t  [NUM_REQ-1:0]         req_src_b;
   logic          [NUM_REQ-1:0][TAG_W-1:0] req_tag;
   logic          [NUM_REQ-1:0]         grant;

   control_bits_t                       alu_ctrl;
   memory_word_t                        alu_src_a;
   memory_word_t                        alu_src_b;
   memory_word_t                        alu_result;
   logic                                alu_take_branch;

   logic                                res_valid;
   logic                                res_ready;
   logic          [TAG_W-1:0]           res_tag;
   memory_word_t                        res_value;
   logic                                res_take_branch;

   modport master (
      input  flush, req_valid, req_ctrl, req_src_a, req_src_b, req_tag,
      input  alu_result, alu_take_branch, res_ready,
      output grant, alu_ctrl, alu_src_a, alu_src_b,
      output res_valid, res_tag, res_value, res_take_branch
   );

   modport slave (
      output flush, req_valid, req_ctrl, req_src_a, req_src_b, req_tag,
      output alu_result, alu_take_branch, res_ready,
      input  grant, alu_ctrl, alu_src_a, alu_src_b,
      input  res_valid, res_tag, res_value, res_take_branch
   );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Wrap-around priority picker: grants the lowest requesting index at or
//   above ptr, wrapping past N-1 back to 0. Purely combinational.
//   Ports: req (N requests), ptr (start index), enable (gate all grants),
//          gnt (one-hot grant), gnt_idx (binary index of gnt, 0 when none).
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   input  logic                 enable,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx
);

   localparam int IDX_W = $clog2(N);

   logic             found;
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   // One extra bit on sum: ptr + offset peaks at 2N-2, then folds back below N.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      sum     = '0;
      cand    = '0;
      for (int off = 0; off < N; off++) begin
         sum = {1'b0, ptr} + (IDX_W + 1)'(off);
         if (sum >= (IDX_W + 1)'(N)) begin
            sum = sum - (IDX_W + 1)'(N);
         end
         cand = sum[IDX_W-1:0];
         if (enable && !found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/alu_scheduler.sv
// ---------------------------------------------------------------------------
// alu_scheduler
//   Shares one combinational ALU among NUM_REQ requesters. Round-robin picks
//   a ready request, registers its operands/control toward the ALU, keeps the
//   ALU busy for the op's latency class, then captures the tagged result into
//   a registered result slot drained by a valid/ready consumer.
//   Ports: clk, reset_n (sync, active-low); bus (alu_scheduler_if.master);
//          dbg_state (FSM state), dbg_rr_ptr (round-robin start index).
// ---------------------------------------------------------------------------
module alu_scheduler
   import alu_scheduler_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int TAG_W       = 4,
   parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
   parameter int DIV_LATENCY = DEFAULT_DIV_LATENCY
) (
   input  logic                       clk,
   input  logic                       reset_n,
   alu_scheduler_if.master            bus,
   output alu_sched_state_e           dbg_state,
   output logic [$clog2(NUM_REQ)-1:0] dbg_rr_ptr
);

   localparam int IDX_W   = $clog2(NUM_REQ);
   localparam int MAX_LAT = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   // count holds the remaining busy cycles minus one, so count==0 marks the
   // cycle whose ALU output gets captured.
   function automatic logic [CNT_W-1:0] busy_cycles(input op_class_e c);
      case (c)
         OPC_MUL: busy_cycles = CNT_W'(MUL_LATENCY - 1);
         OPC_DIV: busy_cycles = CNT_W'(DIV_LATENCY - 1);
         default: busy_cycles = '0;
      endcase
   endfunction

   alu_sched_state_e   state_q, state_d;
   logic [CNT_W-1:0]   count_q;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [TAG_W-1:0]   tag_q;

   logic               slot_free;
   logic               at_end;
   logic               can_issue;
   logic               capture;
   logic               issue;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req     (bus.req_valid),
      .ptr     (rr_ptr_q),
      .enable  (can_issue),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign issue      = |gnt;
   assign bus.grant  = gnt;
   assign dbg_rr_ptr = rr_ptr_q;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state. A grant landing on the capture cycle keeps us in EXEC.
   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (issue) state_d = S_EXEC;
            S_EXEC:  if (capture && !issue) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM: outputs. The result slot is free when empty or draining this
   // cycle; a full, stalled slot blocks both capture and new grants.
   always_comb begin
      slot_free = !bus.res_valid || bus.res_ready;
      at_end    = (state_q == S_EXEC) && (count_q == '0);
      can_issue = ((state_q == S_IDLE) || at_end) && slot_free && !bus.flush;
      capture   = at_end && slot_free && !bus.flush;
      dbg_state = state_q;
   end

   // Busy counter
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (bus.flush) begin
         count_q <= '0;
      end else if (issue) begin
         count_q <= busy_cycles(op_class(bus.req_ctrl[gnt_idx].aluop));
      end else if ((state_q == S_EXEC) && (count_q != '0)) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   // Round-robin pointer: moves past the winner, untouched otherwise.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_ptr_q <= '0;
      end else if (issue) begin
         rr_ptr_q <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // ALU input registers and destination tag. They keep their last values
   // when idle so the ALU inputs do not toggle needlessly.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bus.alu_ctrl  <= '0;
         bus.alu_src_a <= '0;
         bus.alu_src_b <= '0;
         tag_q         <= '0;
      end else if (issue) begin
         bus.alu_ctrl  <= bus.req_ctrl[gnt_idx];
         bus.alu_src_a <= bus.req_src_a[gnt_idx];
         bus.alu_src_b <= bus.req_src_b[gnt_idx];
         tag_q         <= bus.req_tag[gnt_idx];
      end
   end

   // Result slot. A capture coinciding with a drain overwrites in place.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bus.res_valid       <= 1'b0;
         bus.res_tag         <= '0;
         bus.res_value       <= '0;
         bus.res_take_branch <= 1'b0;
      end else if (bus.flush) begin
         bus.res_valid <= 1'b0;
      end else if (capture) begin
         bus.res_valid       <= 1'b1;
         bus.res_tag         <= tag_q;
         bus.res_value       <= bus.alu_result;
         bus.res_take_branch <= bus.alu_take_branch;
      end else if (bus.res_valid && bus.res_ready) begin
         bus.res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_scheduler
//   Bench for alu_scheduler: behavioural ALU, per-requester op queues that
//   follow the grant protocol, and a result scoreboard (exp_q).
// ---------------------------------------------------------------------------
module tb_alu_scheduler;
   import alu_scheduler_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int TAG_W   = 4;
   localparam int EXP_W   = TAG_W + XLEN + 1;

   typedef struct packed {
      control_bits_t      ctrl;
      memory_word_t       a;
      memory_word_t       b;
      logic [TAG_W-1:0]   tag;
   } req_item_t;

   logic             clk;
   logic             reset_n;
   alu_sched_state_e dbg_state;
   logic [1:0]       dbg_rr_ptr;

   req_item_t        rq [NUM_REQ][$];
   logic [EXP_W-1:0] exp_q [$];
   int               ready_mode;   // 0: hold low, 1: hold high, 2: random
   int               n_tests;
   int               n_fail;

   alu_scheduler_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

   alu_scheduler #(
      .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .MUL_LATENCY(3), .DIV_LATENCY(8)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus.master),
      .dbg_state  (dbg_state),
      .dbg_rr_ptr (dbg_rr_ptr)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural ALU ----------------
   function automatic memory_word_t alu_value(input control_bits_t c,
                                              input memory_word_t a,
                                              input memory_word_t b);
      case (c.aluop)
         ALU_ADD:  alu_value = a + b;
         ALU_SUB:  alu_value = a - b;
         ALU_XOR:  alu_value = a ^ b;
         ALU_MUL:  alu_value = a * b;
         ALU_DIV:  alu_value = (b == 0) ? '1 : memory_word_t'($signed(a) / $signed(b));
         ALU_DIVU: alu_value = (b == 0) ? '1 : a / b;
         default:  alu_value = '0;
      endcase
   endfunction

   function automatic logic alu_branch(input control_bits_t c,
                                       input memory_word_t a,
                                       input memory_word_t b);
      if (c.aluop == ALU_BLT) alu_branch = c.usign ? (a < b) : ($signed(a) < $signed(b));
      else                    alu_branch = 1'b0;
   endfunction

   assign bus.alu_result      = alu_value(bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b);
   assign bus.alu_take_branch = alu_branch(bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b);

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_op(input int i, input aluop_e op, input logic usign,
                          input memory_word_t a, input memory_word_t b,
                          input logic [TAG_W-1:0] tag);
      req_item_t it;
      it.ctrl.aluop = op;
      it.ctrl.usign = usign;
      it.a          = a;
      it.b          = b;
      it.tag        = tag;
      rq[i].push_back(it);
   endtask

   task automatic expect_res(input logic [TAG_W-1:0] tag, input memory_word_t v, input logic br);
      exp_q.push_back({tag, v, br});
   endtask

   function automatic bit rq_pending();
      rq_pending = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) rq_pending = 1'b1;
   endfunction

   // Requesters present their queue head just after each rising edge.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rq[i].size() != 0) begin
            bus.req_valid[i] = 1'b1;
            bus.req_ctrl[i]  = rq[i][0].ctrl;
            bus.req_src_a[i] = rq[i][0].a;
            bus.req_src_b[i] = rq[i][0].b;
            bus.req_tag[i]   = rq[i][0].tag;
         end else begin
            bus.req_valid[i] = 1'b0;
         end
      end
      case (ready_mode)
         0:       bus.res_ready = 1'b0;
         1:       bus.res_ready = 1'b1;
         default: bus.res_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Grant observer and result scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.grant != '0) begin
            check("grant_onehot", $onehot(bus.grant), 1);
            check("grant_without_valid", bus.grant & ~bus.req_valid, 0);
            for (int i = 0; i < NUM_REQ; i++)
               if (bus.grant[i] && rq[i].size() != 0) void'(rq[i].pop_front());
         end
         if (bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", {bus.res_tag, bus.res_value}, 0);
            end else begin
               check("result", {bus.res_tag, bus.res_value, bus.res_take_branch}, exp_q.pop_front());
            end
         end
      end
   end

   task automatic do_reset();
      for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
      exp_q.delete();
      bus.flush  = 1'b0;
      ready_mode = 1;
      reset_n    = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("rst_res",   {bus.res_valid, bus.res_tag, bus.res_value, bus.res_take_branch}, 0);
      check("rst_alu",   {bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b}, 0);
      check("rst_state", dbg_state, S_IDLE);
      check("rst_ptr",   dbg_rr_ptr, 0);
      check("rst_grant", bus.grant, 0);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || rq_pending()) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", n < 2000, 1);
      ready_mode = 1;
      repeat (2) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   aluop_e rand_ops [7] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_MUL, ALU_DIV, ALU_DIVU, ALU_BLT};

   initial begin
      logic [3:0]       eg;
      control_bits_t    c;
      memory_word_t     a, b;
      logic [TAG_W-1:0] t;
      n_tests    = 0;
      n_fail     = 0;
      ready_mode = 1;
      reset_n    = 1'b0;
      bus.flush  = 1'b0;

      // 1: single ADD from requester 2
      do_reset();
      push_op(2, ALU_ADD, 1'b0, 5, 7, 3);
      expect_res(3, 12, 1'b0);
      @(negedge clk); check("t1_grant", bus.grant, 4'b0100);
      @(negedge clk); check("t1_early", bus.res_valid, 0);
                      check("t1_state", dbg_state, S_EXEC);
      @(negedge clk); check("t1_valid", bus.res_valid, 1);
                      check("t1_tagval", {bus.res_tag, bus.res_value}, {4'd3, 64'd12});
                      check("t1_ptr", dbg_rr_ptr, 3);
      wait_drain();

      // 2: all four requesters, back-to-back SINGLE ops
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         push_op(i, ALU_ADD, 1'b0, 10 * i + 1, i + 2, 4 + i);
         expect_res(4 + i, 11 * i + 3, 1'b0);
      end
      push_op(0, ALU_XOR, 1'b0, 64'hF0F0, 64'h0FF0, 9);
      expect_res(9, 64'hFF00, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         eg = 4'b0001 << (k % 4);
         check("t2_grant", bus.grant, eg);
      end
      @(negedge clk); check("t2_stream", bus.res_valid, 1);
      @(negedge clk); check("t2_stream", bus.res_valid, 1);
      wait_drain();

      // 3: DIV blocks the pending ADD for DIV_LATENCY-1 cycles
      do_reset();
      push_op(0, ALU_DIV, 1'b0, 100, 7, 1);
      expect_res(1, 14, 1'b0);
      push_op(1, ALU_ADD, 1'b0, 2, 3, 2);
      expect_res(2, 5, 1'b0);
      @(negedge clk); check("t3_grant_div", bus.grant, 4'b0001);
      for (int k = 1; k < 8; k++) begin
         @(negedge clk); check("t3_blocked", bus.grant, 0);
      end
      @(negedge clk); check("t3_grant_add", bus.grant, 4'b0010);
                      check("t3_not_yet", bus.res_valid, 0);
      @(negedge clk); check("t3_div_res", {bus.res_valid, bus.res_value}, {1'b1, 64'd14});
      @(negedge clk); check("t3_add_res", {bus.res_tag, bus.res_value}, {4'd2, 64'd5});
      wait_drain();

      // 4: backpressure stall then drain
      do_reset();
      ready_mode = 0;
      push_op(0, ALU_ADD, 1'b0, 1, 1, 1); expect_res(1, 2, 1'b0);
      push_op(1, ALU_ADD, 1'b0, 2, 2, 2); expect_res(2, 4, 1'b0);
      push_op(2, ALU_ADD, 1'b0, 3, 3, 4); expect_res(4, 6, 1'b0);
      @(negedge clk); check("t4_grant0", bus.grant, 4'b0001);
      @(negedge clk); check("t4_grant1", bus.grant, 4'b0010);
      for (int k = 2; k < 6; k++) begin
         @(negedge clk);
         check("t4_stall_grant", bus.grant, 0);
         check("t4_stall_res", {bus.res_valid, bus.res_tag, bus.res_value}, {1'b1, 4'd1, 64'd2});
      end
      ready_mode = 1;
      @(negedge clk); check("t4_grant2", bus.grant, 4'b0100);
      wait_drain();

      // 5: flush in the middle of a DIV
      do_reset();
      push_op(0, ALU_DIV, 1'b0, 100, 7, 1);
      @(negedge clk); check("t5_grant_div", bus.grant, 4'b0001);
      push_op(1, ALU_ADD, 1'b0, 4, 5, 6);
      expect_res(6, 9, 1'b0);
      repeat (3) begin
         @(negedge clk); check("t5_blocked", bus.grant, 0);
      end
      @(posedge clk); #1 bus.flush = 1'b1;
      @(negedge clk); check("t5_flush_grant", bus.grant, 0);
      @(posedge clk); #1 bus.flush = 1'b0;
      @(negedge clk); check("t5_state", dbg_state, S_IDLE);
                      check("t5_no_res", bus.res_valid, 0);
                      check("t5_ptr_kept", dbg_rr_ptr, 1);
                      check("t5_regrant", bus.grant, 4'b0010);
      @(negedge clk); check("t5_no_res2", bus.res_valid, 0);
      @(negedge clk); check("t5_add_res", {bus.res_valid, bus.res_value}, {1'b1, 64'd9});
      wait_drain();

      // 6: signed vs unsigned less-than branch
      do_reset();
      push_op(0, ALU_BLT, 1'b0, '1, 1, 5); expect_res(5, 0, 1'b1);
      push_op(0, ALU_BLT, 1'b1, '1, 1, 6); expect_res(6, 0, 1'b0);
      wait_drain();

      // 7: random mixed-latency ops on one requester, random backpressure
      do_reset();
      ready_mode = 2;
      for (int k = 0; k < 40; k++) begin
         c.aluop = rand_ops[$urandom_range(0, 6)];
         c.usign = 1'($urandom_range(0, 1));
         a       = {$urandom, $urandom};
         b       = memory_word_t'($urandom_range(1, 1000));
         t       = TAG_W'($urandom_range(0, 15));
         push_op(1, c.aluop, c.usign, a, b, t);
         expect_res(t, alu_value(c, a, b), alu_branch(c, a, b));
      end
      wait_drain();

      // 8: reset in the middle of a DIV leaves no result behind
      do_reset();
      push_op(0, ALU_DIV, 1'b0, 50, 5, 7);
      repeat (3) @(negedge clk);
      do_reset();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk); check("t8_no_res", bus.res_valid, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Issue scheduler that shares the single combinational `alu` between `NUM_REQ` reservation-station requesters. It round-robin arbitrates ready requests and latches the winner's operands and control bits into the ALU input registers. It holds the ALU for the op class latency (single, MUL, DIV) and delivers the tagged result and branch decision on a registered result port with backpressure.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `TAG_W`, 4: destination tag width.
- `MUL_LATENCY`, 3: ALU-busy cycles for MUL-class ops (≥1).
- `DIV_LATENCY`, 8: ALU-busy cycles for DIV-class ops (≥1).
- `clk` in 1: clock. Single clock domain.
- `reset_n` in 1: reset. Synchronous, active-low.
- `flush` in 1: squash the in-flight op and pending result.
- `req_valid` in NUM_REQ: requester i holds an op ready to execute.
- `req_ctrl` in NUM_REQ×control_bits: per-requester control bits (`aluop`, `usign`).
- `req_src_a`, `req_src_b` in NUM_REQ×MemoryWord: operands.
- `req_tag` in NUM_REQ×TAG_W: destination tag.
- `grant` out NUM_REQ: one-hot, combinational; requester i is accepted this cycle.
- `alu_ctrl` out control_bits: registered, drives `alu.ctrl_bits`.
- `alu_src_a`, `alu_src_b` out MemoryWord: registered, drive the `alu` operands.
- `alu_result` in MemoryWord: from `alu.result`.
- `alu_take_branch` in 1: from `alu.take_branch`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_tag` out TAG_W, `res_value` out MemoryWord, `res_take_branch` out 1: registered result.

## Operation
- Op class is decoded from `aluop`:
  - DIV = DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
  - MUL = MUL, MULH, MULHU, MULHSU, MULW.
  - All other ops are SINGLE, latency 1.
- FSM states: IDLE and EXEC.
  - IDLE→EXEC on grant.
  - In EXEC, `count` decrements each cycle. At `count==0` the ALU outputs are captured into the result register.
  - EXEC→EXEC if a new grant occurs in the same cycle as the capture; otherwise EXEC→IDLE.
- `can_issue` = (IDLE or (EXEC and `count==0`)) and (!`res_valid` or `res_ready`) and !`flush`.
- Grant rule:
  - Grant the lowest index ≥ `rr_ptr` (with wrap) among asserted `req_valid`, only when `can_issue`.
  - `rr_ptr` ← granted index+1 mod NUM_REQ.
  - `rr_ptr` is unchanged when nothing is granted.
- On grant:
  - `alu_ctrl`, `alu_src_a`, `alu_src_b` and the internal tag register are loaded.
  - `count` ← latency−1.
- Requester protocol: a requester holds `req_*` stable until it sees `grant[i]`, then deasserts or presents its next op in the following cycle. `grant` is never asserted for a requester whose `req_valid` is low.
- Result register:
  - Loads on capture: `res_valid` ← 1, plus tag, value and take_branch.
  - Clears (`res_valid` ← 0) on `res_valid & res_ready` when there is no simultaneous capture.
  - Simultaneous capture and drain: the new result replaces the old one and `res_valid` stays 1.
- `alu_ctrl`, `alu_src_a` and `alu_src_b` hold their last values in IDLE. The outputs are don't-care, but the values stay stable to save power.
- `flush`:
  - FSM ← IDLE and `res_valid` ← 0.
  - No grant and no capture that cycle.
  - `rr_ptr` is preserved.
- Divide-by-zero and overflow results are whatever `alu` produces; the scheduler does no special handling.
- Reset values: FSM IDLE, `count` 0, `rr_ptr` 0, `grant` 0, `res_valid` 0, `res_tag` 0, `res_value` 0, `res_take_branch` 0, `alu_ctrl` 0, `alu_src_a` 0, `alu_src_b` 0. `reset_n` low mid-operation abandons the op with no result.

## Timing
- Grant in cycle T. Operands are at the ALU in T+1. For latency L, capture happens at the end of cycle T+L and `res_valid` is high from T+L+1.
- SINGLE ops are back-to-back: one grant per cycle and one result per cycle while `res_ready`=1.
- MUL blocks new grants for MUL_LATENCY−1 cycles after its grant; DIV blocks them for DIV_LATENCY−1 cycles.
- Stall: if `res_valid` and !`res_ready`, there is no grant and EXEC at `count==0` holds (no capture) until `res_ready`.
- `grant` depends combinationally on `req_valid`, state and `res_ready`. There is no combinational path from `alu_result` to `grant`.

## Structure
- Shared package additions:
  - `op_class_e` {OPC_SINGLE, OPC_MUL, OPC_DIV}.
  - `alu_sched_state_e` {S_IDLE, S_EXEC}.
  - Function `op_class(aluop)`.
  - Default latency constants.
- Sub-module `rr_arbiter` (parameter N; inputs `req`, `ptr`, `enable`; outputs one-hot `gnt` and `gnt_idx`) holds the wrap-around priority logic.
- `alu` is instantiated by the parent, not inside this block.

## Test plan
- Reset, then requester 2 issues ADD 5+7, tag 3, with `res_ready`=1 → `grant`=0100 at T; `res_valid` at T+2 with `res_tag`=3, `res_value`=12; `rr_ptr`=3.
- All four `req_valid` high with SINGLE ops, `res_ready`=1 → grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; one result per cycle in the same order.
- DIV 100/7 with DIV_LATENCY=8, then ADD pending → no grant for 7 cycles; DIV `res_value`=14 at T+9; ADD granted at T+8 with result at T+10.
- Hold `res_ready`=0 with a result pending and a SINGLE op in EXEC → `res_*` stable, `grant`=0, no capture; raise `res_ready` → results drain in order with no loss or duplication.
- `flush` during DIV at count 4 → `res_valid` stays 0, FSM IDLE next cycle; a pending request is granted the cycle after `flush` drops.
- BLT −1 vs 1 (signed) → `res_take_branch`=1; BLTU with the same operands → 0.
